// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver:
// digit count, active-low hex segment table and the dark-output patterns.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF    = 4'hF;

  // Active-low gfedcba codes, entry n is the glyph for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low 7-segment (gfedcba) decoder.
module hex7seg
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame value snapshot.
// Optional leading-zero blanking is compiled in when SEG_LZB_EN is defined.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        CP,
  input  logic        CR,
  input  logic        EN,
  input  logic [15:0] D,
  input  logic [3:0]  DP,
  output logic [NUM_DIGITS-1:0] AN,
  output logic [7:0]  SEG
);

  localparam int PS_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [PS_W-1:0]       r_ps;
  logic [1:0]            r_idx;
  logic [15:0]           r_val;
  logic [3:0]            r_dpv;
  logic [NUM_DIGITS-1:0] r_an;
  logic [7:0]            r_seg;

  logic                  w_tick;
  logic [3:0]            w_nib;
  logic [6:0]            w_hex;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_an;
  logic [7:0]            w_seg;

  assign w_tick = (r_ps == PS_W'(SCAN_DIV - 1));
  assign w_nib  = r_val[{r_idx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .i_nib (w_nib),
    .o_seg (w_hex)
  );

`ifdef SEG_LZB_EN
  // A digit goes dark when it and every more-significant nibble are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd1:    w_blank = (r_val[15:4]  == 12'd0);
      2'd2:    w_blank = (r_val[15:8]  == 8'd0);
      2'd3:    w_blank = (r_val[15:12] == 4'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_an = AN_OFF;
    if (!w_blank) w_an[r_idx] = 1'b0;
    w_seg = w_blank ? SEG_BLANK : {~r_dpv[r_idx], w_hex};
  end

  // Scan state and registered output stage (outputs lag r_idx by one cycle).
  always_ff @(posedge CP) begin
    if (CR) begin
      r_ps  <= '0;
      r_idx <= 2'd0;
      r_val <= 16'd0;
      r_dpv <= 4'd0;
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_ps <= w_tick ? '0 : r_ps + PS_W'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
      if (w_tick && (r_idx == 2'd3)) begin
        r_val <= D;
        r_dpv <= DP;
      end
      if (EN) begin
        r_an  <= w_an;
        r_seg <= w_seg;
      end else begin
        r_an  <= AN_OFF;
        r_seg <= SEG_BLANK;
      end
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with SCAN_DIV = 4: directed scenarios plus random
// traffic, checked against a cycle-count based model of the display.
module tb_seg_scan_driver;

  localparam int SD    = 4;
  localparam int FRAME = 4 * SD;

  logic        CP = 1'b0;
  logic        CR = 1'b1;
  logic        EN = 1'b1;
  logic [15:0] D  = 16'h0000;
  logic [3:0]  DP = 4'h0;
  logic [3:0]  AN;
  logic [7:0]  SEG;

  int vectors    = 0;
  int miscompares = 0;

  // Model state: edges since reset release, and the latched frame.
  int          m_k   = 0;
  logic [15:0] m_val = 16'h0;
  logic [3:0]  m_dpv = 4'h0;

  seg_scan_driver #(.SCAN_DIV(SD)) dut (
    .CP  (CP),
    .CR  (CR),
    .EN  (EN),
    .D   (D),
    .DP  (DP),
    .AN  (AN),
    .SEG (SEG)
  );

  always #5 CP = ~CP;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: predict outputs from the model, clock, check, advance model.
  task automatic step(input string tag);
    int          digit;
    logic [15:0] upper;
    logic        lit;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    digit = (m_k / SD) % 4;
    upper = m_val >> (4 * digit);
    lit   = EN;
`ifdef SEG_LZB_EN
    if (digit != 0 && upper == 16'h0) lit = 1'b0;
`endif
    if (CR || !lit) begin
      e_an  = 4'hF;
      e_seg = 8'hFF;
    end else begin
      e_an  = ~(4'b0001 << digit);
      e_seg = {~m_dpv[digit], glyph(upper[3:0])};
    end
    @(posedge CP);
    #1;
    if (CR) begin
      m_k   = 0;
      m_val = 16'h0;
      m_dpv = 4'h0;
    end else begin
      if (m_k % FRAME == FRAME - 1) begin
        m_val = D;
        m_dpv = DP;
      end
      m_k++;
    end
    chk({tag, ".an"}, {4'h0, AN}, {4'h0, e_an});
    chk({tag, ".seg"}, SEG, e_seg);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic align();
    while (m_k % FRAME != 0) step("align");
  endtask

  logic [3:0] dir_an [4];
  logic [7:0] dir_seg[4];

  // Walk one full frame checking each slot against the directed tables.
  task automatic frame_directed(input string tag);
    for (int s = 0; s < FRAME; s++) begin
      step(tag);
      chk({tag, ".dir_an"}, {4'h0, AN}, {4'h0, dir_an[s / SD]});
      chk({tag, ".dir_seg"}, SEG, dir_seg[s / SD]);
    end
  endtask

  initial begin
    // Reset with a nonzero value on D.
    CR = 1'b1; D = 16'h1234; DP = 4'b0100; EN = 1'b1;
    step("reset");
    chk("reset.an", {4'h0, AN}, 8'h0F);
    step("reset");
    chk("reset.seg", SEG, 8'hFF);
    CR = 1'b0;
    step("post_reset");
    chk("first.an", {4'h0, AN}, 8'h0E);
    chk("first.seg", SEG, 8'hC0);
    run("pre_snap", FRAME - 1);

    // Scan of 1234 with dp on digit 2.
    dir_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    dir_seg = '{8'h99, 8'hB0, 8'h24, 8'hF9};
    frame_directed("scan");

    // Change D while digit 1 is active; current frame must finish as 1234.
    run("tear", SD);
    D = 16'hABCD; DP = 4'h0;
    run("tear", 3 * SD);
    dir_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    frame_directed("tear_next");

    // Drop EN mid-slot for 6 cycles.
    run("en", 2);
    EN = 1'b0;
    step("en_off");
    chk("en_off.an", {4'h0, AN}, 8'h0F);
    chk("en_off.seg", SEG, 8'hFF);
    run("en_off", 5);
    EN = 1'b1;
    run("en_on", 6);

    // Leading zeros.
    align();
    D = 16'h0050;
    run("lz_load", FRAME);
`ifdef SEG_LZB_EN
    dir_an  = '{4'hE, 4'hD, 4'hF, 4'hF};
    dir_seg = '{8'hC0, 8'h92, 8'hFF, 8'hFF};
`else
    dir_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    dir_seg = '{8'hC0, 8'h92, 8'hC0, 8'hC0};
`endif
    frame_directed("lz_0050");
    D = 16'h0000;
    run("lz_zero", 2 * FRAME);

    // Mid-frame reset during digit 2 with D = FFFF.
    align();
    D = 16'hFFFF;
    run("mid", 2 * SD + 1);
    CR = 1'b1;
    step("mid_rst");
    chk("mid_rst.an", {4'h0, AN}, 8'h0F);
    CR = 1'b0;
    step("mid_rel");
    step("mid_zero");
    chk("mid_zero.an", {4'h0, AN}, 8'h0E);
    chk("mid_zero.seg", SEG, 8'hC0);
    run("mid_wait", 2 * FRAME);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) D  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) DP = 4'($urandom);
      if ($urandom_range(0, 9) == 0) EN = ~EN;
      if ($urandom_range(0, 3) == 0) D[15:8] = 8'h00;
      CR = ($urandom_range(0, 199) == 0);
      step("rand");
    end
    CR = 1'b0; EN = 1'b1;
    run("tail", FRAME);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed 4-digit 7-segment display driver that sits directly downstream of the cascaded 4-bit counter stages. It takes the four 4-bit counter outputs as a 16-bit value, snapshots it once per scan frame, and drives active-low anode and segment lines one digit at a time at a parameterised refresh rate. Outputs are registered and glitch-free; the displayed value never tears mid-frame.

## Interface
- SCAN_DIV, 50000: CP cycles per digit slot (1 kHz per digit at 50 MHz); legal range ≥ 2.
- CP  input  1  clock; all state changes on rising edge.
- CR  input  1  synchronous active-high reset.
- EN  input  1  display enable; low blanks all digits.
- D  input  16  value to display; D[3:0] is digit 0 (rightmost), D[15:12] is digit 3.
- DP  input  4  decimal point request per digit, bit i maps to digit i.
- AN  output  4  digit anodes, active-low, one-hot-low when lit.
- SEG  output  8  segments, active-low, SEG[6:0] = g,f,e,d,c,b,a and SEG[7] = dp.

## Operation
- Prescaler PS counts 0 to SCAN_DIV-1, then wraps to 0. TICK = (PS == SCAN_DIV-1). Prescaler width is ceil(log2(SCAN_DIV)).
- Digit index IDX is 2 bits and advances 0→1→2→3→0 on each TICK. Wrap from 3 to 0 is natural 2-bit overflow.
- Frame snapshot: on a TICK with IDX == 3, D is latched into VAL[15:0] and DP into DPV[3:0]. All four digits of one frame therefore show the same sample.
- Output register, computed from the current IDX, VAL and DPV every cycle:
  - AN: bit IDX = 0, all other bits = 1.
  - SEG[6:0]: hex decode of VAL nibble IDX.
  - SEG[7]: ~DPV[IDX].
- Hex decode, active-low, bit order gfedcba:
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30
  - 4 = 7'h19, 5 = 7'h12, 6 = 7'h02, 7 = 7'h78
  - 8 = 7'h00, 9 = 7'h10, A = 7'h08, b = 7'h03
  - C = 7'h46, d = 7'h21, E = 7'h06, F = 7'h0E
- EN low:
  - AN = 4'hF and SEG = 8'hFF from the next edge onward.
  - PS, IDX and the snapshot continue running, so re-enabling resumes mid-frame with no restart.
- CR:
  - PS = 0, IDX = 0, VAL = 0, DPV = 0.
  - AN = 4'hF, SEG = 8'hFF. Outputs stay dark for the cycle after reset.
  - CR overrides EN, TICK and snapshot in the same cycle.
  - CR mid-frame discards the frame; the display shows 0000 until the first snapshot.

## Timing
- AN/SEG lag IDX by exactly one CP cycle (registered output stage).
- Digit slot length is exactly SCAN_DIV cycles; a frame is 4·SCAN_DIV cycles.
- First snapshot happens 4·SCAN_DIV cycles after CR deasserts. Before that, digits show "0" (7'h40) once the output register has loaded.
- A change on D becomes visible at most 4·SCAN_DIV+1 cycles later, and at the earliest on digit 0 of the next frame.
- D and DP need only be stable at the rising edge where TICK is high and IDX == 3; no handshake is required.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking is enabled.
  - Digit i (i = 3, 2, 1) is blanked when VAL nibbles i..3 are all zero.
  - Blanked means AN bit i stays 1 during its slot and SEG = 8'hFF.
  - Digit 0 is never blanked.
  - DPV has no effect on blanked digits.
- SEG_LZB_EN undefined: all four digits are always lit and zeros are shown explicitly.

## Structure
- Shared package seg_pkg:
  - NUM_DIGITS = 4.
  - The 16-entry active-low segment constant table.
  - SEG_BLANK = 8'hFF and AN_OFF = 4'hF.
- Sub-module hex7seg: combinational 4-bit to 7-bit active-low decoder using the seg_pkg table. It is instantiated once, fed by the muxed nibble.

## Test plan
All scenarios use SCAN_DIV = 4.
1. Reset: CR high for 2 cycles with D = 16'h1234. Required: AN = 4'hF and SEG = 8'hFF during reset and the following cycle; then AN = 4'hE and SEG = 8'hC0 (digit 0 shows "0") until the first snapshot.
2. Scan: D = 16'h1234 and DP = 4'b0100 held. After the snapshot, AN sequence is E, D, B, 7, with each value held exactly 4 cycles. SEG sequence is 8'h99, 8'hB0, 8'h24, 8'hF9. Digit 2 has SEG[7] = 0, so it reads 8'h24 with dp lit.
3. Tearing: change D from 16'h1234 to 16'hABCD while IDX = 1. The current frame completes as 1234; the next frame shows SEG values 8'hA1 (d), 8'hC6 (C), 8'h83 (b), 8'h88 (A).
4. Enable: drop EN for 6 cycles mid-slot. AN = 4'hF and SEG = 8'hFF one cycle after EN falls. On re-enable, the lit digit matches the free-running IDX.
5. With SEG_LZB_EN and D = 16'h0050: digits 3 and 2 keep AN high (dark); digit 1 shows 8'h92 and digit 0 shows 8'hC0. With D = 0, only digit 0 lights, showing 8'hC0.
6. Mid-frame reset: assert CR while IDX = 2 and D = 16'hFFFF. Required: PS = 0 and IDX = 0 on the next cycle, and the display shows 0000 until the next snapshot.
